// File: rtl/lcd_timing_engine.sv
// RGB-LCD timing generator: H/V counters, sync/DE generation, pixel fetch request and a
// two-stage registered pin path with built-in test patterns.
module lcd_timing_engine #(
    parameter int unsigned  R_W      = 5,
    parameter int unsigned  G_W      = 6,
    parameter int unsigned  B_W      = 5,
    parameter int unsigned  H_ACTIVE = 800,
    parameter int unsigned  H_FP     = 40,
    parameter int unsigned  H_SYNC   = 48,
    parameter int unsigned  H_BP     = 40,
    parameter int unsigned  V_ACTIVE = 480,
    parameter int unsigned  V_FP     = 13,
    parameter int unsigned  V_SYNC   = 3,
    parameter int unsigned  V_BP     = 29,
    parameter bit           HS_POL   = 1'b0,
    parameter bit           VS_POL   = 1'b0,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW       = $clog2(H_TOTAL),
    localparam int unsigned VW       = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [1:0]     pattern_mode,
    input  logic [R_W-1:0] pix_r_in,
    input  logic [G_W-1:0] pix_g_in,
    input  logic [B_W-1:0] pix_b_in,
    output logic           pix_req,
    output logic [HW-1:0]  pix_x,
    output logic [VW-1:0]  pix_y,
    output logic           frame_start,
    output logic [R_W-1:0] lcd_r,
    output logic [G_W-1:0] lcd_g,
    output logic [B_W-1:0] lcd_b,
    output logic           lcd_hsync,
    output logic           lcd_vsync,
    output logic           lcd_den
);
    localparam int unsigned   BW       = HW + 3;
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
    localparam logic [BW-1:0] BAR_W_C  = BW'(H_ACTIVE / 8);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [1:0]    mode_q, mode_cur;
    logic          run, den0, hs0, vs0, hb3, vb3;

    logic          den1_q, hs1_q, vs1_q, chk1_q;
    logic [1:0]    mode1_q;
    logic [HW-1:0] x1_q;

    logic [BW-1:0]  bar;
    logic           bar_ok;
    logic [R_W-1:0] r_c;
    logic [G_W-1:0] g_c;
    logic [B_W-1:0] b_c;

    // Checkerboard uses bit 3 of each coordinate; tiny counters have no such bit.
    if (HW > 3) begin : g_hb3
        assign hb3 = h_q[3];
    end else begin : g_hb3_none
        assign hb3 = 1'b0;
    end
    if (VW > 3) begin : g_vb3
        assign vb3 = v_q[3];
    end else begin : g_vb3_none
        assign vb3 = 1'b0;
    end

    assign pix_x = h_q;
    assign pix_y = v_q;

    always_comb begin
        run         = enable & ~reset;
        frame_start = run & (h_q == '0) & (v_q == '0);
        // New mode applies from the frame_start pixel itself.
        mode_cur    = frame_start ? pattern_mode : mode_q;
        den0        = run & (h_q < H_ACT_C) & (v_q < V_ACT_C);
        hs0         = run & (h_q >= HS_BEG_C) & (h_q < HS_END_C);
        vs0         = run & (v_q >= VS_BEG_C) & (v_q < VS_END_C);
        pix_req     = den0 & (mode_cur == 2'd0);
        h_d         = h_q;
        v_d         = v_q;
        if (!run) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST_C) begin
            h_d = '0;
            v_d = (v_q == V_LAST_C) ? '0 : v_q + VW'(1);
        end else begin
            h_d = h_q + HW'(1);
        end
    end

    always_comb begin
        bar    = {3'b000, x1_q} / BAR_W_C;
        bar_ok = ~|bar[BW-1:3];
        r_c    = '0;
        g_c    = '0;
        b_c    = '0;
        if (den1_q) begin
            case (mode1_q)
                2'd0: begin
                    r_c = pix_r_in;
                    g_c = pix_g_in;
                    b_c = pix_b_in;
                end
                // Bars white..black map to rgb = ~{bar[1], bar[2], bar[0]}.
                2'd1: begin
                    r_c = {R_W{bar_ok & ~bar[1]}};
                    g_c = {G_W{bar_ok & ~bar[2]}};
                    b_c = {B_W{bar_ok & ~bar[0]}};
                end
                2'd2: begin
                    r_c = {R_W{chk1_q}};
                    g_c = {G_W{chk1_q}};
                    b_c = {B_W{chk1_q}};
                end
                default: begin
                    r_c = '1;
                    g_c = '1;
                    b_c = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q       <= '0;
            v_q       <= '0;
            mode_q    <= 2'd0;
            den1_q    <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            chk1_q    <= 1'b0;
            mode1_q   <= 2'd0;
            x1_q      <= '0;
            lcd_r     <= '1;
            lcd_g     <= '1;
            lcd_b     <= '1;
            lcd_hsync <= ~HS_POL;
            lcd_vsync <= ~VS_POL;
            lcd_den   <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            mode_q    <= mode_cur;
            den1_q    <= den0;
            hs1_q     <= hs0;
            vs1_q     <= vs0;
            chk1_q    <= hb3 ^ vb3;
            mode1_q   <= mode_cur;
            x1_q      <= h_q;
            lcd_r     <= r_c;
            lcd_g     <= g_c;
            lcd_b     <= b_c;
            lcd_hsync <= hs1_q ? HS_POL : ~HS_POL;
            lcd_vsync <= vs1_q ? VS_POL : ~VS_POL;
            lcd_den   <= den1_q;
        end
    end
endmodule

// File: tb/tb_lcd_timing_engine.sv
// Scoreboard bench for lcd_timing_engine in a 14x7 configuration: expected pixels are queued per
// frame, a negedge monitor pops one per lcd_den cycle; timing is checked per observed cycle.
module tb_lcd_timing_engine;
    localparam bit [7:0] BAR_R = 8'b00110011;
    localparam bit [7:0] BAR_G = 8'b00001111;
    localparam bit [7:0] BAR_B = 8'b01010101;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] pattern_mode;
    logic [4:0] pix_r_in = 5'h15;
    logic [5:0] pix_g_in = 6'h2a;
    logic [4:0] pix_b_in = 5'h0a;
    logic       pix_req;
    logic [3:0] pix_x;
    logic [2:0] pix_y;
    logic       frame_start;
    logic [4:0] lcd_r;
    logic [5:0] lcd_g;
    logic [4:0] lcd_b;
    logic       lcd_hsync;
    logic       lcd_vsync;
    logic       lcd_den;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lcd_timing_engine #(
        .R_W(5), .G_W(6), .B_W(5),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pattern_mode(pattern_mode),
        .pix_r_in(pix_r_in), .pix_g_in(pix_g_in), .pix_b_in(pix_b_in),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_den(lcd_den)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-buffer model with 1-cycle read latency; junk when not requested.
    always @(posedge clk) begin
        if (pix_req) begin
            pix_r_in <= 5'(pix_x);
            pix_g_in <= 6'(pix_y) + 6'd32;
            pix_b_in <= 5'd31 - 5'(pix_x);
        end else begin
            pix_r_in <= 5'h15;
            pix_g_in <= 6'h2a;
            pix_b_in <= 5'h0a;
        end
    end

    always @(negedge clk) begin
        pix_t e;
        if (!reset && lcd_den) begin
            chk("exp_avail", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pix_r", int'(lcd_r), int'(e.r));
                chk("pix_g", int'(lcd_g), int'(e.g));
                chk("pix_b", int'(lcd_b), int'(e.b));
            end
        end
    end

    function automatic pix_t exp_pix(input logic [1:0] m, input int x, input int y);
        pix_t       p;
        logic [7:0] br, bg, bb;
        logic       c;
        br = BAR_R;
        bg = BAR_G;
        bb = BAR_B;
        c  = x[3] ^ y[3];
        case (m)
            2'd0: begin
                p.r = 5'(x);
                p.g = 6'(y + 32);
                p.b = 5'(31 - x);
            end
            2'd1: begin
                p.r = {5{br[x[2:0]]}};
                p.g = {6{bg[x[2:0]]}};
                p.b = {5{bb[x[2:0]]}};
            end
            2'd2: begin
                p.r = {5{c}};
                p.g = {6{c}};
                p.b = {5{c}};
            end
            default: p = '1;
        endcase
        return p;
    endfunction

    task automatic push_frame(input logic [1:0] m, input int npix);
        for (int i = 0; i < npix; i++) exp_q.push_back(exp_pix(m, i % 8, i / 8));
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Called while observing the frame's h=0,v=0 cycle.
    task automatic run_frame(input logic [1:0] m, input int chg_k, input logic [1:0] chg_mode,
                             input int stop_k, input int npix);
        int req_n, den_n, fs_n, hs_n, vs_n;
        req_n = 0; den_n = 0; fs_n = 0; hs_n = 0; vs_n = 0;
        push_frame(m, npix);
        for (int k = 0; k < 98; k++) begin
            if (k > 0) step();
            if (k == 0) begin
                chk("fs_origin", int'(frame_start), 1);
                chk("x_origin", int'(pix_x), 0);
                chk("y_origin", int'(pix_y), 0);
                chk("req_origin", int'(pix_req), (m == 2'd0) ? 1 : 0);
            end
            fs_n  += int'(frame_start);
            req_n += int'(pix_req);
            den_n += int'(lcd_den);
            hs_n  += int'(!lcd_hsync);
            vs_n  += int'(!lcd_vsync);
            chk("hsync", int'(lcd_hsync), (k % 14 >= 12) ? 0 : 1);
            chk("vsync", int'(lcd_vsync), (k >= 72 && k < 86) ? 0 : 1);
            if (k == chg_k) pattern_mode = chg_mode;
            if (k == stop_k) begin
                enable = 1'b0;
                #1;
                chk("req_drop", int'(pix_req), 0);
                step();
                chk("x_cleared", int'(pix_x), 0);
                chk("y_cleared", int'(pix_y), 0);
                chk("fs_disabled", int'(frame_start), 0);
                step();
                chk("den_drained", int'(lcd_den), 0);
                chk("r_drained", int'(lcd_r), 0);
                return;
            end
        end
        chk("fs_per_frame", fs_n, 1);
        chk("req_per_frame", req_n, (m == 2'd0) ? 32 : 0);
        chk("den_per_frame", den_n, 32);
        chk("hs_low_per_frame", hs_n, 14);
        chk("vs_low_per_frame", vs_n, 14);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        pattern_mode = 2'd0;
        step();
        step();
        chk("rst_r", int'(lcd_r), 31);
        chk("rst_g", int'(lcd_g), 63);
        chk("rst_b", int'(lcd_b), 31);
        chk("rst_hsync", int'(lcd_hsync), 1);
        chk("rst_vsync", int'(lcd_vsync), 1);
        chk("rst_den", int'(lcd_den), 0);
        chk("rst_req", int'(pix_req), 0);
        reset = 1'b0;
        step();
        step();
        chk("idle_r", int'(lcd_r), 0);
        chk("idle_den", int'(lcd_den), 0);
        chk("idle_hsync", int'(lcd_hsync), 1);
        chk("idle_fs", int'(frame_start), 0);

        // Enable, then hit reset asynchronously at h=5 of line 1.
        enable = 1'b1;
        #1;
        chk("fs_enable_rise", int'(frame_start), 1);
        push_frame(2'd0, 12);
        repeat (19) step();
        #1;
        reset = 1'b1;
        #1;
        chk("arst_r", int'(lcd_r), 31);
        chk("arst_g", int'(lcd_g), 63);
        chk("arst_b", int'(lcd_b), 31);
        chk("arst_den", int'(lcd_den), 0);
        chk("arst_hsync", int'(lcd_hsync), 1);
        chk("arst_vsync", int'(lcd_vsync), 1);
        chk("arst_req", int'(pix_req), 0);
        chk("arst_fs", int'(frame_start), 0);
        chk("arst_x", int'(pix_x), 0);
        chk("arst_queue", exp_q.size(), 0);
        step();
        reset = 1'b0;
        #1;
        chk("fs_after_reset", int'(frame_start), 1);

        run_frame(2'd0, 40, 2'd2, -1, 32);
        step();
        run_frame(2'd2, 50, 2'd1, -1, 32);
        step();
        run_frame(2'd1, 30, 2'd3, -1, 32);
        step();
        run_frame(2'd3, 60, 2'd0, -1, 32);
        step();
        run_frame(2'd0, -1, 2'd0, 17, 11);

        repeat (3) step();
        chk("dis_den", int'(lcd_den), 0);
        chk("dis_hsync", int'(lcd_hsync), 1);
        chk("dis_vsync", int'(lcd_vsync), 1);
        chk("dis_r", int'(lcd_r), 0);
        chk("dis_req", int'(pix_req), 0);
        chk("dis_queue", exp_q.size(), 0);
        enable = 1'b1;
        #1;
        chk("fs_reenable", int'(frame_start), 1);
        run_frame(2'd0, -1, 2'd0, -1, 32);
        step();
        chk("fs_period", int'(frame_start), 1);
        step();
        chk("final_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
